// File: rtl/mac_operand_sequencer.sv
// ---------------------------------------------------------------------------
// mac_operand_sequencer
//
// Purpose:
//   Host-side driver for a 4-operand dot-product MAC. It collects four operand
//   bytes (A0, A1, B0, B1) from a valid/ready byte stream and holds them, with
//   the mode select, stable at the MAC inputs. It then waits out the MAC
//   pipeline latency, captures the result and offers it on a second
//   valid/ready handshake. Only one transaction is in flight at a time.
//
// Ports:
//   iCLK, iRST_N        clock (rising edge), asynchronous active-low reset
//   iBYTE, iBYTE_VALID  operand byte stream in
//   oBYTE_READY         sequencer can accept a byte (registered)
//   iMODE               MAC select, sampled with byte 0 only
//   oA0/oA1/oB0/oB1     operands to the MAC
//   oSEL                mode to the MAC (1: A0*B0+A1*B1, 0: adds A0*A1*B0*B1)
//   iR                  MAC result
//   oRES, oRES_VALID    captured result and its valid flag
//   iRES_READY          consumer accepts oRES
//   oBUSY               high while waiting on the MAC or holding a result
//   oMISMATCH           (only with MAC_SEQ_CHECK_EN) captured result differed
//                       from the locally computed expectation
//
// Configuration:
//   `define MAC_SEQ_CHECK_EN to add the oMISMATCH port and the local result
//   check. Without it there is no port and no multiplier logic.
// ---------------------------------------------------------------------------
module mac_operand_sequencer #(
  parameter int DATA_W  = 8,
  parameter int RES_W   = 17,
  parameter int LATENCY = 2
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [DATA_W-1:0] iBYTE,
  input  logic              iBYTE_VALID,
  output logic              oBYTE_READY,
  input  logic              iMODE,
  output logic [DATA_W-1:0] oA0,
  output logic [DATA_W-1:0] oA1,
  output logic [DATA_W-1:0] oB0,
  output logic [DATA_W-1:0] oB1,
  output logic              oSEL,
  input  logic [RES_W-1:0]  iR,
  output logic [RES_W-1:0]  oRES,
  output logic              oRES_VALID,
  input  logic              iRES_READY,
  output logic              oBUSY
`ifdef MAC_SEQ_CHECK_EN
  ,
  output logic              oMISMATCH
`endif
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RESULT  = 2'd2;

  logic [1:0] r_state;
  logic [1:0] r_idx;
  logic [3:0] r_cnt;

  logic w_accept;
  logic w_lastByte;

  assign w_accept   = iBYTE_VALID & oBYTE_READY;
  assign w_lastByte = (r_idx == 2'd3);

  // Busy covers both waiting on the MAC and holding an unconsumed result.
  assign oBUSY = (r_state != S_COLLECT);

`ifdef MAC_SEQ_CHECK_EN
  // Local reference of the MAC formula, evaluated modulo 2^RES_W so that the
  // wrap in mode 0 matches what the MAC produces.
  logic [RES_W-1:0] w_a0x;
  logic [RES_W-1:0] w_a1x;
  logic [RES_W-1:0] w_b0x;
  logic [RES_W-1:0] w_b1x;
  logic [RES_W-1:0] w_expected;

  assign w_a0x = RES_W'(oA0);
  assign w_a1x = RES_W'(oA1);
  assign w_b0x = RES_W'(oB0);
  assign w_b1x = RES_W'(oB1);
  assign w_expected = w_a0x * w_b0x + w_a1x * w_b1x
                    + (oSEL ? '0 : w_a0x * w_a1x * w_b0x * w_b1x);
`endif

  // Main sequencer. Operand bytes land directly in their output registers,
  // so the MAC sees a stable operand set as soon as byte 3 is accepted.
  // oBYTE_READY is registered: it stays low out of reset and rises on the
  // first edge after release.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state     <= S_COLLECT;
      r_idx       <= 2'd0;
      r_cnt       <= 4'd0;
      oBYTE_READY <= 1'b0;
      oA0         <= '0;
      oA1         <= '0;
      oB0         <= '0;
      oB1         <= '0;
      oSEL        <= 1'b0;
      oRES        <= '0;
      oRES_VALID  <= 1'b0;
`ifdef MAC_SEQ_CHECK_EN
      oMISMATCH   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_COLLECT: begin
          oBYTE_READY <= ~(w_accept & w_lastByte);
          if (w_accept) begin
            case (r_idx)
              2'd0: begin
                oA0  <= iBYTE;
                oSEL <= iMODE;
              end
              2'd1:    oA1 <= iBYTE;
              2'd2:    oB0 <= iBYTE;
              default: oB1 <= iBYTE;
            endcase
            if (w_lastByte) begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(LATENCY);
              r_idx   <= 2'd0;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end

        // Counter reaching zero means the MAC output now reflects the held
        // operands; capture happens LATENCY+1 edges after the last byte.
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            oRES       <= iR;
            oRES_VALID <= 1'b1;
            r_state    <= S_RESULT;
`ifdef MAC_SEQ_CHECK_EN
            oMISMATCH  <= (w_expected != iR);
`endif
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        // oRES keeps its value after hand-off until the next capture.
        S_RESULT: begin
          if (iRES_READY) begin
            oRES_VALID  <= 1'b0;
            r_idx       <= 2'd0;
            r_state     <= S_COLLECT;
            oBYTE_READY <= 1'b1;
          end
        end

        default: begin
          r_state     <= S_COLLECT;
          r_idx       <= 2'd0;
          oBYTE_READY <= 1'b0;
          oRES_VALID  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mac_operand_sequencer
//
// Purpose:
//   Self-checking bench for mac_operand_sequencer. A stand-in MAC with a
//   two-register pipeline drives iR. A transaction-level reference model
//   predicts every DUT output from the bytes offered and the handshake rules,
//   and a compare process checks all outputs against it on every falling
//   edge. Directed transactions pin the model with hand-computed results.
//
// Configuration:
//   Define MAC_SEQ_CHECK_EN to also check oMISMATCH.
// ---------------------------------------------------------------------------
module tb_mac_operand_sequencer;

  localparam int LAT = 2;

  logic        clk;
  logic        rst_n;
  logic [7:0]  iByte;
  logic        byteValid;
  logic        byteReady;
  logic        mode;
  logic [7:0]  a0, a1, b0, b1;
  logic        sel;
  logic [16:0] macR;
  logic [16:0] res;
  logic        resValid;
  logic        resReady;
  logic        busy;
`ifdef MAC_SEQ_CHECK_EN
  logic        mismatch;
`endif

  int nCompared   = 0;
  int nMismatched = 0;
  bit cmpEn       = 1'b0;
  bit forceZero   = 1'b0;

  mac_operand_sequencer #(.DATA_W(8), .RES_W(17), .LATENCY(LAT)) dut (
    .iCLK        (clk),
    .iRST_N      (rst_n),
    .iBYTE       (iByte),
    .iBYTE_VALID (byteValid),
    .oBYTE_READY (byteReady),
    .iMODE       (mode),
    .oA0         (a0),
    .oA1         (a1),
    .oB0         (b0),
    .oB1         (b1),
    .oSEL        (sel),
    .iR          (macR),
    .oRES        (res),
    .oRES_VALID  (resValid),
    .iRES_READY  (resReady),
    .oBUSY       (busy)
`ifdef MAC_SEQ_CHECK_EN
    ,
    .oMISMATCH   (mismatch)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain arithmetic form of the MAC formula, wrapped to 17 bits.
  function automatic logic [16:0] dot(input logic [7:0] x0, input logic [7:0] x1,
                                      input logic [7:0] y0, input logic [7:0] y1,
                                      input logic s);
    longint t;
    t = longint'(x0) * longint'(y0) + longint'(x1) * longint'(y1);
    if (!s) t = t + longint'(x0) * longint'(x1) * longint'(y0) * longint'(y1);
    return t[16:0];
  endfunction

  // Stand-in MAC: two pipeline registers between operands and result.
  logic [16:0] macS1, macS2;
  always @(posedge clk) begin
    macS1 <= dot(a0, a1, b0, b1, sel);
    macS2 <= macS1;
  end
  assign macR = forceZero ? 17'd0 : macS2;

  // Reference model: tracks how many bytes of the current set have arrived,
  // the cycle on which the result is due, and whether a result is pending.
  logic [7:0]  mOps [4];
  logic        mSel, mReady, mValid, mMis;
  logic [16:0] mRes;
  int          mNext, mDue;
  longint      cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mOps[i] = 8'd0;
      mSel = 1'b0; mReady = 1'b0; mValid = 1'b0; mMis = 1'b0;
      mRes = 17'd0; mNext = 0; mDue = -1;
    end else begin
      cyc = cyc + 1;
      if (mValid) begin
        if (resReady) begin
          mValid = 1'b0;
          mReady = 1'b1;
          mNext  = 0;
        end
      end else if (mDue >= 0) begin
        if (cyc == longint'(mDue)) begin
          mRes   = forceZero ? 17'd0 : dot(mOps[0], mOps[1], mOps[2], mOps[3], mSel);
          mMis   = (mRes != dot(mOps[0], mOps[1], mOps[2], mOps[3], mSel));
          mValid = 1'b1;
          mDue   = -1;
        end
      end else if (byteValid && mReady) begin
        mOps[mNext] = iByte;
        if (mNext == 0) mSel = mode;
        if (mNext == 3) begin
          mReady = 1'b0;
          mDue   = int'(cyc) + LAT + 1;
        end
        mNext = mNext + 1;
      end else begin
        mReady = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Every falling edge: all outputs against the model.
  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("byteReady", 32'(byteReady), 32'(mReady));
      checkOutput("a0", 32'(a0), 32'(mOps[0]));
      checkOutput("a1", 32'(a1), 32'(mOps[1]));
      checkOutput("b0", 32'(b0), 32'(mOps[2]));
      checkOutput("b1", 32'(b1), 32'(mOps[3]));
      checkOutput("sel", 32'(sel), 32'(mSel));
      checkOutput("res", 32'(res), 32'(mRes));
      checkOutput("resValid", 32'(resValid), 32'(mValid));
      checkOutput("busy", 32'(busy), 32'(mValid || (mDue >= 0)));
`ifdef MAC_SEQ_CHECK_EN
      checkOutput("mismatch", 32'(mismatch), 32'(mMis));
`endif
    end
  end

  // Offer four bytes, gap cycles of idle before each; returns on the falling
  // edge right after the acceptance edge of byte 3 with valid dropped.
  task automatic applyStimulus(input logic [7:0] bytes [4], input logic m, input int gap);
    int guard;
    for (int i = 0; i < 4; i++) begin
      byteValid = 1'b0;
      repeat (gap) @(negedge clk);
      byteValid = 1'b1;
      iByte     = bytes[i];
      mode      = (i == 0) ? m : 1'($urandom_range(0, 1));
      guard     = 0;
      while (!byteReady && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) checkOutput("acceptTimeout", 32'(guard), 32'd0);
      @(negedge clk);
    end
    byteValid = 1'b0;
  endtask

  // Wait for the result, check latency and optional literal, stall the
  // consumer for stall cycles while offering an unwanted byte.
  task automatic awaitResult(input int stall, input bit checkLit, input logic [16:0] lit);
    int k = 0;
    while (!resValid && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("latency", 32'(k), 32'(LAT + 1));
    if (checkLit) checkOutput("resLiteral", 32'(res), 32'(lit));
    if (stall > 0) begin
      byteValid = 1'b1;
      iByte     = 8'hAA;
      repeat (stall) begin
        @(negedge clk);
        checkOutput("stallValid", 32'(resValid), 32'd1);
        checkOutput("stallReady", 32'(byteReady), 32'd0);
        if (checkLit) checkOutput("stallRes", 32'(res), 32'(lit));
      end
      byteValid = 1'b0;
    end
    resReady = 1'b1;
    @(negedge clk);
    checkOutput("validDrop", 32'(resValid), 32'd0);
  endtask

  task automatic runTxn(input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] y0,
                        input logic [7:0] y1, input logic m, input int gap, input int stall,
                        input bit checkLit, input logic [16:0] lit);
    logic [7:0] bytes [4];
    bytes[0] = x0; bytes[1] = x1; bytes[2] = y0; bytes[3] = y1;
    resReady = (stall == 0);
    applyStimulus(bytes, m, gap);
    awaitResult(stall, checkLit, lit);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] ab [4];
    rst_n = 1'b0; byteValid = 1'b0; iByte = 8'd0; mode = 1'b0; resReady = 1'b1;
    @(posedge clk);
    cmpEn = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rstReady", 32'(byteReady), 32'd0);
    checkOutput("rstRes", 32'(res), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    $display("[TB] directed transactions");
    runTxn(8'd3, 8'd4, 8'd5, 8'd6, 1'b1, 0, 0, 1'b1, 17'd39);
    runTxn(8'd3, 8'd4, 8'd5, 8'd6, 1'b0, 0, 0, 1'b1, 17'd399);
    checkOutput("sel0", 32'(sel), 32'd0);
    runTxn(8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 0, 0, 1'b1, 17'h1FC02);
    runTxn(8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 0, 0, 1'b1, 17'h1F803);
    runTxn(8'd10, 8'd20, 8'd30, 8'd40, 1'b1, 2, 5, 1'b1, 17'd1100);
    checkOutput("stallA0", 32'(a0), 32'd10);

    $display("[TB] reset during WAIT");
    ab[0] = 8'd9; ab[1] = 8'd8; ab[2] = 8'd7; ab[3] = 8'd6;
    resReady = 1'b1;
    applyStimulus(ab, 1'b0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abortA0", 32'(a0), 32'd0);
    checkOutput("abortB1", 32'(b1), 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortReady", 32'(byteReady), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    runTxn(8'd1, 8'd2, 8'd3, 8'd4, 1'b1, 0, 0, 1'b1, 17'd11);

    $display("[TB] forced-zero MAC result");
    forceZero = 1'b1;
    runTxn(8'd3, 8'd4, 8'd5, 8'd6, 1'b1, 0, 0, 1'b1, 17'd0);
`ifdef MAC_SEQ_CHECK_EN
    checkOutput("mismatchSet", 32'(mismatch), 32'd1);
`endif
    forceZero = 1'b0;
    runTxn(8'd3, 8'd4, 8'd5, 8'd6, 1'b1, 0, 0, 1'b1, 17'd39);
`ifdef MAC_SEQ_CHECK_EN
    checkOutput("mismatchClr", 32'(mismatch), 32'd0);
`endif

    $display("[TB] randomized transactions");
    for (int t = 0; t < 30; t++) begin
      runTxn(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 3)), 1'b0, 17'd0);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mac_operand_sequencer.md
Name: mac_operand_sequencer

Overview:
- Host-side driver for the 4-operand dot-product MAC unit (8-bit operands A0, A1, B0, B1; select input; 17-bit registered result).
- Accepts a byte stream over a valid/ready handshake and assembles four operands. Drives them, plus the mode select, stable into the MAC.
- Waits out the MAC pipeline latency, captures the 17-bit result and returns it over a second valid/ready handshake.
- Handles exactly one transaction at a time; a new operand set is not collected until the previous result has been consumed.

Parameters:
- DATA_W, 8: operand and byte width.
- RES_W, 17: result width; must match the MAC output width.
- LATENCY, 2: MAC clock edges from operands stable at its inputs to result valid at its output; legal range 1..15.

Ports:
- iCLK  input  1  clock; all logic is on the rising edge.
- iRST_N  input  1  asynchronous active-low reset.
- iBYTE  input  DATA_W  operand byte stream.
- iBYTE_VALID  input  1  iBYTE is valid.
- oBYTE_READY  output  1  sequencer can accept a byte.
- iMODE  input  1  MAC select for this transaction; sampled only with byte 0.
- oA0, oA1, oB0, oB1  output  DATA_W each  operands to the MAC.
- oSEL  output  1  mode to the MAC (1 = A0*B0 + A1*B1; 0 = the same plus A0*A1*B0*B1).
- iR  input  RES_W  MAC result.
- oRES  output  RES_W  captured result.
- oRES_VALID  output  1  oRES is valid.
- iRES_READY  input  1  consumer accepts oRES.
- oBUSY  output  1  high in WAIT and RESULT.

Behaviour:
- Reset (iRST_N low, asynchronous):
  - state = COLLECT, byte index = 0, wait counter = 0.
  - oA0/oA1/oB0/oB1 = 0, oSEL = 0, oRES = 0, oRES_VALID = 0, oBUSY = 0, oBYTE_READY = 0.
- Release from reset: oBYTE_READY is registered and rises on the first rising edge after release.
- States: COLLECT -> WAIT -> RESULT -> COLLECT.
- COLLECT:
  - oBYTE_READY = 1. A byte is accepted on an edge with iBYTE_VALID & oBYTE_READY.
  - Byte order is A0, A1, B0, B1; each accepted byte is written straight into its output register.
  - iMODE is latched into oSEL on acceptance of byte 0.
  - Gaps (iBYTE_VALID low) are allowed between bytes. The index holds and the partial operands hold.
  - On acceptance of byte 3: go to WAIT, load counter = LATENCY, drop oBYTE_READY on that same edge.
- WAIT:
  - Operands and oSEL are held stable; the MAC re-registers them every cycle.
  - The counter decrements each edge. On the edge where the counter is 0, iR is captured into oRES, oRES_VALID is set and the state goes to RESULT.
  - The result is therefore captured LATENCY+1 edges after the byte-3 acceptance edge.
- RESULT:
  - oRES and oRES_VALID are held until an edge with iRES_READY = 1.
  - On that edge: oRES_VALID clears, the index resets to 0, the state goes to COLLECT and oBYTE_READY rises.
  - oRES keeps its value until the next capture.
- Bytes presented outside COLLECT are not accepted; oBYTE_READY = 0 throughout WAIT and RESULT.
- iRES_READY is ignored outside RESULT.
- Width: oRES is iR verbatim, with no truncation or extension by this block. The MAC's modulo-2^RES_W wrap in mode 0 is passed through unchanged.
- Reset mid-operation: reset asserted in any state aborts the transaction immediately (asynchronously). All outputs return to their reset values and the partial operand set is discarded.

Optional Feature:
- Macro: MAC_SEQ_CHECK_EN.
- With the macro defined:
  - Adds output oMISMATCH (1 bit, reset 0).
  - At capture, the block computes its own expected result from the held operands and oSEL, using the same formula truncated to RES_W bits.
  - oMISMATCH is set if the expected result differs from iR, and cleared at the next capture that matches.
  - oMISMATCH is sticky only until the next capture; it is cleared by reset.
- Without the macro: no port, no multipliers, no check logic.

Test Plan:
- Bytes 3, 4, 5, 6 back-to-back, iMODE = 1, iRES_READY = 1, LATENCY = 2 -> oRES = 39 (0x00027); oRES_VALID rises 3 edges after the byte-6 acceptance edge and is high for 1 cycle.
- Same bytes with iMODE = 0 -> oRES = 399 (0x0018F), oSEL = 0 throughout the transaction.
- All bytes 255: iMODE = 1 -> oRES = 0x1FC02; iMODE = 0 -> oRES = 0x1F803 (wrap).
- iBYTE_VALID with 2-cycle gaps between bytes, and iRES_READY low for 5 cycles after oRES_VALID -> operands correct; oRES stable and oBYTE_READY = 0 during the stall; a byte offered during the stall is not consumed.
- Reset asserted in WAIT, then a fresh transaction with bytes 1, 2, 3, 4 and iMODE = 1 -> all outputs 0 during reset; next oRES = 11; no residue from the aborted set.
- With MAC_SEQ_CHECK_EN defined and iR forced to 0x00000 for bytes 3, 4, 5, 6 with iMODE = 1 -> oMISMATCH = 1. A following correct transaction -> oMISMATCH = 0.
